// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl_pkg
// Brief   : State encodings and halfword-select constants for the SRAM sequencer
// Revision: 1.0
// ============================================================================
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic c_half_lo = 1'b0;
  localparam logic c_half_hi = 1'b1;

  // The halfword being transferred follows directly from the phase state.
  function automatic logic half_sel(input state_t s);
    return (s == ST_HIGH) ? c_half_hi : c_half_lo;
  endfunction

endpackage : sram_ctrl_pkg
`default_nettype wire

// File: rtl/sram_ctrl_phase_counter.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl_phase_counter
// Brief   : Counts 0..PHASE_CYC-1 within one SRAM phase and flags terminal count
// Revision: 1.0
// ============================================================================
module sram_ctrl_phase_counter #(
  parameter int PHASE_CYC = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc
);

  localparam int CNT_W = (PHASE_CYC > 2) ? $clog2(PHASE_CYC) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign tc = (r_cnt == CNT_W'(PHASE_CYC - 1));

  // Wrapping on terminal count lets the HIGH phase start from zero without a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule : sram_ctrl_phase_counter
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sram_ctrl
// Brief   : Splits a 32-bit load/store into two timed halfword SRAM phases
// Revision: 1.0
// ============================================================================
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int PHASE_CYC = 3,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [31:0]         address,
  input  logic [2*DATA_W-1:0] write_data,
  output logic [2*DATA_W-1:0] read_data,
  output logic                ready,
  output logic [ADDR_W-1:0]   sram_addr,
  input  logic [DATA_W-1:0]   sram_dq_i,
  output logic [DATA_W-1:0]   sram_dq_o,
  output logic                sram_dq_oe,
  output logic                sram_we_n,
  output logic                sram_oe_n,
  output logic                sram_ce_n,
  output logic                sram_ub_n,
  output logic                sram_lb_n
);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_op_wr;
  logic [ADDR_W-2:0]     r_idx;
  logic [2*DATA_W-1:0]   r_wdata;
  logic [2*DATA_W-1:0]   r_read_data;
  logic                  w_tc;
  logic                  w_clr;
  logic                  w_accept;
  logic                  w_sample;
  logic                  w_half;
  logic                  w_unused;

  // Byte offset and bits above the SRAM range are deliberately dropped.
  assign w_unused = ^{address[31:ADDR_W+1], address[1:0]};

  sram_ctrl_phase_counter #(
    .PHASE_CYC (PHASE_CYC)
  ) u_phase_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .tc    (w_tc)
  );

  assign w_half    = half_sel(r_state);
  assign w_sample  = ((r_state == ST_LOW) || (r_state == ST_HIGH)) && !r_op_wr && w_tc;
  assign read_data = r_read_data;

  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    w_accept     = 1'b0;
    ready        = 1'b0;
    sram_addr    = '0;
    sram_dq_o    = '0;
    sram_dq_oe   = 1'b0;
    sram_we_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_ce_n    = 1'b1;
    sram_ub_n    = 1'b1;
    sram_lb_n    = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        ready = ~(rd_en | wr_en);
        w_clr = 1'b1;
        if (rd_en || wr_en) begin
          w_accept     = 1'b1;
          w_next_state = ST_LOW;
        end
      end
      ST_LOW, ST_HIGH: begin
        sram_ce_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
        sram_addr = {r_idx, w_half};
        if (r_op_wr) begin
          sram_dq_oe = 1'b1;
          sram_dq_o  = (w_half == c_half_hi) ? r_wdata[2*DATA_W-1:DATA_W] : r_wdata[DATA_W-1:0];
          // Releasing WE on the last cycle gives the SRAM data hold time.
          sram_we_n  = w_tc;
        end else begin
          sram_oe_n = 1'b0;
        end
        if (w_tc) begin
          w_next_state = (r_state == ST_LOW) ? ST_HIGH : ST_DONE;
        end
      end
      ST_DONE: begin
        ready        = 1'b1;
        w_clr        = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op_wr     <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_op_wr <= wr_en;
        r_idx   <= address[ADDR_W:2];
        r_wdata <= write_data;
      end
      if (w_sample) begin
        if (w_half == c_half_hi) begin
          r_read_data[2*DATA_W-1:DATA_W] <= sram_dq_i;
        end else begin
          r_read_data[DATA_W-1:0] <= sram_dq_i;
        end
      end
    end
  end

endmodule : sram_ctrl
`default_nettype wire
